// File: rtl/hazard5_decode_predict.sv
// hazard5_decode_predict
//
// Decode-stage PC tracking, stall generation and jump prediction for Hazard5.
// Conditional branches are predicted from a table of 2-bit saturating counters
// indexed by PC. The table is trained from execute. With BHT_DEPTH=0 the table
// is removed and prediction falls back to static backward-taken /
// forward-not-taken. JAL is always predicted taken. JALR is never predicted.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   d_instr               decompressed instruction currently in CIR
//   d_instr_is_32bit      CIR instruction uses a 32-bit encoding
//   fd_cir_vld            number of valid halfwords in CIR (0..2)
//   x_stall, flush_d_x    execute stall, and bubble insertion into X
//   f_jump_rdy/now/target fetch jump handshake and the address of any taken jump
//   x_bht_update/taken/index  branch resolution from X, used to train the table
//   d_stall, df_cir_use   decode stall, and halfwords consumed from CIR
//   df_cir_lock           hold CIR while a predicted jump waits for a stall to clear
//   d_jump_req/target     combinational predicted-jump request to fetch
//   d_pc                  PC of the instruction in CIR
//   dx_*                  D->X pipeline register (PC, branch info, recovery address)
module hazard5_decode_predict #(
    parameter int                W_ADDR       = 32,
    parameter logic [W_ADDR-1:0] RESET_VECTOR = '0,
    parameter int                BHT_DEPTH    = 16,
    parameter int                W_IDX        = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       d_instr,
    input  logic              d_instr_is_32bit,
    input  logic [1:0]        fd_cir_vld,
    input  logic              x_stall,
    input  logic              flush_d_x,
    input  logic              f_jump_rdy,
    input  logic              f_jump_now,
    input  logic [W_ADDR-1:0] f_jump_target,
    input  logic              x_bht_update,
    input  logic              x_bht_taken,
    input  logic [W_IDX-1:0]  x_bht_index,
    output logic              d_stall,
    output logic [1:0]        df_cir_use,
    output logic              df_cir_lock,
    output logic              d_jump_req,
    output logic [W_ADDR-1:0] d_jump_target,
    output logic [W_ADDR-1:0] d_pc,
    output logic [W_ADDR-1:0] dx_pc,
    output logic [W_ADDR-1:0] dx_mispredict_addr,
    output logic              dx_branch_vld,
    output logic              dx_pred_taken,
    output logic [W_IDX-1:0]  dx_bht_index
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Saturating 2-bit counter step: up on taken, down on not-taken.
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'd1;
        else
            return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    logic [W_ADDR-1:0] pc;
    logic [W_ADDR-1:0] pc_next;
    logic              lock_prev;
    logic              starved;
    logic              is_branch;
    logic              is_jal;
    logic              backward;
    logic              bht_pred;
    logic              taken;
    logic              jump_en;
    logic              lock_assert;
    logic              bubble;
    logic [W_IDX-1:0]  idx;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_j;
    logic [W_ADDR-1:0] branch_target;
    logic [W_ADDR-1:0] jal_target;

    assign is_branch = d_instr[6:0] == OPC_BRANCH;
    assign is_jal    = d_instr[6:0] == OPC_JAL;

    assign imm_b = {{20{d_instr[31]}}, d_instr[7], d_instr[30:25], d_instr[11:8], 1'b0};
    assign imm_j = {{12{d_instr[31]}}, d_instr[19:12], d_instr[20], d_instr[30:21], 1'b0};

    // Sign bit of the B-type immediate marks a backward branch.
    assign backward = d_instr[31];

    assign branch_target = pc + W_ADDR'(imm_b);
    assign jal_target    = pc + W_ADDR'(imm_j);
    assign pc_next       = pc + (d_instr_is_32bit ? W_ADDR'(4) : W_ADDR'(2));

    assign idx = pc[W_IDX:1];

    generate
        if (BHT_DEPTH > 0) begin : g_bht
            logic [1:0] bht [BHT_DEPTH];
            logic [1:0] ctr;

            // Combinational read: an update in the same cycle is not yet visible.
            assign ctr      = bht[idx];
            assign bht_pred = ctr[1] | ((ctr == 2'b01) & backward);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < BHT_DEPTH; i++)
                        bht[i] <= 2'b01;
                end else if (x_bht_update) begin
                    bht[x_bht_index] <= ctr_step(bht[x_bht_index], x_bht_taken);
                end
            end
        end else begin : g_static
            logic unused_bht_inputs;
            assign unused_bht_inputs = ^{x_bht_update, x_bht_taken, x_bht_index};
            assign bht_pred = backward;
        end
    endgenerate

    assign starved = (fd_cir_vld == 2'd0) | ((fd_cir_vld == 2'd1) & d_instr_is_32bit);
    assign taken   = is_jal | (is_branch & bht_pred);

    // Once a jump has been handed to fetch under a stall, the CIR instruction
    // must not request it again while it waits.
    assign jump_en       = !starved & !lock_prev;
    assign d_jump_req    = jump_en & taken;
    assign d_jump_target = is_jal ? jal_target : branch_target;

    assign d_stall     = x_stall | starved | (d_jump_req & !f_jump_rdy);
    assign df_cir_use  = d_stall ? 2'd0 : (d_instr_is_32bit ? 2'd2 : 2'd1);
    assign lock_assert = d_jump_req & f_jump_rdy & d_stall;
    assign df_cir_lock = (lock_prev & d_stall) | lock_assert;
    assign d_pc        = pc;
    assign bubble      = d_stall | flush_d_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_VECTOR;
            lock_prev <= 1'b0;
        end else begin
            if (f_jump_now)
                pc <= f_jump_target;
            else if (!d_stall)
                pc <= pc_next;
            lock_prev <= df_cir_lock;
        end
    end

    // ---- D -> X stage boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_pc              <= '0;
            dx_bht_index       <= '0;
            dx_branch_vld      <= 1'b0;
            dx_pred_taken      <= 1'b0;
            dx_mispredict_addr <= '0;
        end else if (!x_stall) begin
            dx_pc              <= pc;
            dx_bht_index       <= idx;
            dx_branch_vld      <= is_branch & !bubble;
            dx_pred_taken      <= taken & !bubble;
            // Recovery goes the opposite way to the prediction.
            dx_mispredict_addr <= taken ? pc_next : branch_target;
        end
    end

endmodule

// File: doc/hazard5_decode_predict.md
# hazard5_decode_predict

Decode-stage PC, stall and jump-prediction unit for Hazard5, sitting between fetch (CIR) and execute. It replaces fixed backward-taken/forward-not-taken prediction with a parametrised table of 2-bit saturating counters, updated from execute. Any branch, in either direction, can be predicted taken. It also carries the target address needed for recovery in both directions. Instruction field decode (ALU/mem controls) stays outside this block; it consumes the already-decompressed instruction.

## Interface
- W_ADDR, 32, address width.
- RESET_VECTOR, 32'h0, PC after reset.
- BHT_DEPTH, 16, counter entries; power of 2, 2..64. Set to 0 for static backward-taken/forward-not-taken prediction with no table.
- W_IDX, log2(BHT_DEPTH) (1 when BHT_DEPTH=0), table index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- d_instr  in  32  decompressed instruction in CIR.
- d_instr_is_32bit  in  1  CIR holds a 32-bit encoding.
- fd_cir_vld  in  2  valid halfwords in CIR (0, 1 or 2).
- x_stall  in  1  execute stalled.
- flush_d_x  in  1  insert bubble into X.
- f_jump_rdy  in  1  fetch can accept a jump this cycle.
- f_jump_now  in  1  a jump (from any source) is taken this cycle.
- f_jump_target  in  W_ADDR  address of that jump.
- x_bht_update  in  1  a conditional branch resolved in X.
- x_bht_taken  in  1  resolved direction.
- x_bht_index  in  W_IDX  index carried with that branch.
- d_stall  out  1  decode stalled.
- df_cir_use  out  2  halfwords consumed.
- df_cir_lock  out  1  hold CIR contents.
- d_jump_req  out  1  predicted jump request.
- d_jump_target  out  W_ADDR  predicted target.
- d_pc  out  W_ADDR  PC of CIR instruction.
- dx_pc  out  W_ADDR  registered PC.
- dx_mispredict_addr  out  W_ADDR  recovery address.
- dx_branch_vld  out  1  X holds a conditional branch.
- dx_pred_taken  out  1  that branch was predicted taken.
- dx_bht_index  out  W_IDX  index used for the prediction.

## Operation
- Starvation:
  - starved = (fd_cir_vld==0) | (fd_cir_vld==1 & d_instr_is_32bit).
  - d_stall = x_stall | starved | (d_jump_req & !f_jump_rdy).
  - df_cir_use = 0 when d_stall is high; otherwise 2 for a 32-bit instruction and 1 for a 16-bit one.
- PC:
  - pc_next = pc + 4 for a 32-bit instruction, pc + 2 for a 16-bit one.
  - When f_jump_now is high, pc loads f_jump_target.
  - Otherwise, when d_stall is low, pc loads pc_next.
  - d_pc = pc.
- CIR lock:
  - Lock asserts when d_jump_req & f_jump_rdy & d_stall.
  - Lock holds until a cycle with d_stall low; lock_prev is a register.
  - df_cir_lock = (lock_prev & d_stall) | assert.
- Prediction:
  - jump_en = !starved & !lock_prev.
  - idx = pc[W_IDX:1]; ctr = bht[idx].
  - The branch immediate is the RV32 B-type immediate; a branch is backward when imm sign = 1.
  - Branch (opcode 1100011) with BHT_DEPTH>0: taken = ctr[1] | (ctr==2'b01 & backward).
  - Branch with BHT_DEPTH=0: taken = backward.
  - JAL: always taken.
  - JALR: never predicted.
  - d_jump_req = jump_en & taken.
  - d_jump_target = pc + (JAL ? J-immediate : B-immediate); 32-bit add, wraps modulo 2^W_ADDR.
- BHT update:
  - When x_bht_update is high, bht[x_bht_index] counts up (saturating at 3) if x_bht_taken, otherwise counts down (saturating at 0).
  - A prediction read and an update to the same index in the same cycle: the read sees the pre-update value.
  - Updates occur regardless of the stall inputs.
- D->X register (updates when x_stall is low):
  - dx_pc <= pc.
  - dx_bht_index <= idx.
  - dx_branch_vld <= is-branch.
  - dx_pred_taken <= taken.
  - dx_mispredict_addr <= taken ? pc_next : branch target.
  - If d_stall | flush_d_x: dx_branch_vld and dx_pred_taken are cleared to 0 (bubble).

## Timing
- Reset values:
  - pc = RESET_VECTOR; lock_prev = 0.
  - All dx_* outputs = 0.
  - Every BHT entry = 2'b01.
- Outputs from reset state: d_jump_req 0 (starved); d_stall 1 while fd_cir_vld==0.
- d_jump_req and d_jump_target are combinational from CIR and pc; fetch sees the request the same cycle.
- A BHT update is visible to a prediction read on the cycle after x_bht_update.
- Reset asserted mid-operation clears pc, the lock and the whole BHT asynchronously; the next fetch starts at RESET_VECTOR.
- f_jump_now with d_stall high still loads pc.

## Test plan
- Reset, then CIR = BEQ with +8 offset at pc 0 -> d_jump_req=0; when X is free, dx_branch_vld=1, dx_pred_taken=0, dx_mispredict_addr=0x8.
- Same BEQ, resolved taken twice via x_bht_update at index 0 (counter 01->10->11) -> next fetch of pc 0 gives d_jump_req=1, d_jump_target=0x8, dx_mispredict_addr=0x4.
- Backward BNE (offset -4) at pc 0x10 after reset -> taken (ctr 01, backward). Resolve not-taken once (ctr 00) -> d_jump_req=0.
- JAL with x_stall=1 and f_jump_rdy=1 -> df_cir_lock=1 until x_stall drops. While locked, d_jump_req=0; pc = target once f_jump_now fires.
- fd_cir_vld=1 with a 32-bit instruction -> d_stall=1, df_cir_use=0, d_jump_req=0; dx bubble with dx_branch_vld=0.
- BHT_DEPTH=0 build: forward branch not taken and backward branch taken for any resolve history; the x_bht_update inputs are ignored.
